// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame and synchronizer defaults plus the receive FSM state encoding.
package spi_pkg;

  localparam int unsigned DataWDefault      = 16;
  localparam int unsigned SyncStagesDefault = 2;

  typedef enum logic [1:0] {
    StWaitIdle = 2'd0,
    StIdle     = 2'd1,
    StShift    = 2'd2,
    StDone     = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module spi_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // The cast drops the oldest stage, which keeps Stages == 1 legal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= Stages'({sync_q, d_i});
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive-only slave: synchronizes CS/SCK/MOSI into clk, shifts frames MSB first and
// hands each completed frame to a valid/ready output register with overrun and framing flags.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DataWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_l,
  input  logic              spi_clk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic [4:0]        counter
);

  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic cs_s, sck_s, mosi_s;

  spi_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d_i (spi_cs_l),
    .q_o (cs_s)
  );

  spi_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d_i (spi_clk),
    .q_o (sck_s)
  );

  spi_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d_i (spi_data),
    .q_o (mosi_s)
  );

  spi_state_e              state_q;
  logic                    sck_prev_q;
  logic [DATA_W-1:0]       shift_q;
  logic [CntW-1:0]         counter_q;
  logic                    xfer_q;
  logic [DATA_W-1:0]       rx_data_q;
  logic                    rx_valid_q;
  logic                    overrun_q;
  logic                    frame_err_q;
  logic [SYNC_STAGES-1:0]  prime_q;

  logic sck_rise;
  logic primed;

  assign sck_rise = sck_s & ~sck_prev_q;
  // The CS synchronizer resets to "high"; only trust it once real samples have flushed through.
  assign primed   = prime_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StWaitIdle;
      sck_prev_q  <= 1'b0;
      shift_q     <= '0;
      counter_q   <= '0;
      xfer_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      prime_q     <= '0;
    end else begin
      sck_prev_q  <= sck_s;
      prime_q     <= SYNC_STAGES'({prime_q, 1'b1});
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      xfer_q      <= 1'b0;

      if (xfer_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      unique case (state_q)
        StWaitIdle: begin
          if (primed && cs_s) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (!cs_s) begin
            state_q   <= StShift;
            counter_q <= '0;
            shift_q   <= '0;
          end
        end
        StShift: begin
          // A CS rise takes priority over an edge seen in the same cycle.
          if (cs_s) begin
            if (counter_q != '0) begin
              frame_err_q <= 1'b1;
            end
            counter_q <= '0;
            state_q   <= StIdle;
          end else if (sck_rise) begin
            shift_q   <= {shift_q[DATA_W-2:0], mosi_s};
            counter_q <= counter_q + 1'b1;
            if (counter_q == LastBit) begin
              state_q <= StDone;
              xfer_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          if (cs_s) begin
            state_q   <= StIdle;
            counter_q <= '0;
          end
        end
        default: state_q <= StWaitIdle;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign counter   = counter_q;

endmodule
